apb_nslave_bridge: RTL and testbench
====================================

APB_NSLAVE_BRIDGE -- requirements
Module: apb_nslave_bridge

Interface
REQ-001 SHALL provide parameter AW, default 8, address width in bits.
REQ-002 SHALL provide parameter DW, default 8, data width in bits.
REQ-003 SHALL provide parameter NS, default 4, slave count; power of two, 2..16.
REQ-004 SHALL provide parameter TIMEOUT, default 16, maximum ACCESS cycles; used only under APB_TIMEOUT_EN.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: pclk  in  1  APB clock, all logic on rising edge.
REQ-006 presetn  in  1  asynchronous active-low reset.
REQ-007 transfer  in  1  request strobe from requester.
REQ-008 READ_WRITE  in  1  1 = read, 0 = write.
REQ-009 apb_write_paddr  in  AW  write address.
REQ-010 apb_write_data  in  DW  write data.
REQ-011 apb_read_paddr  in  AW  read address.
REQ-012 apb_read_data_out  out  DW  last completed read data.
REQ-013 busy  out  1  high in SETUP or ACCESS.
REQ-014 done  out  1  one-cycle pulse on transfer completion.
REQ-015 slverr_out  out  1  error status of the last completed transfer.
REQ-016 paddr  out  AW; pwrite  out  1; pwdata  out  DW; penable  out  1.
REQ-017 psel  out  NS  one-hot slave select.
REQ-018 prdata  in  NS*DW  slave i read data in bits [i*DW +: DW].
REQ-019 pready  in  NS; pslverr  in  NS  per-slave ready and error.

Function
REQ-020 FSM SHALL have states IDLE, SETUP, ACCESS; reset state IDLE.
REQ-021 In IDLE with transfer=1 at a rising edge: latch READ_WRITE, the address (apb_read_paddr if read, else apb_write_paddr) and apb_write_data; go to SETUP.
REQ-022 Slave index SHALL be paddr[AW-1 -: $clog2(NS)]; only that psel bit is asserted.
REQ-023 SETUP: psel bit high, penable=0, paddr/pwrite/pwdata driven from the latch; always go to ACCESS after one cycle.
REQ-024 ACCESS: penable=1; paddr/pwrite/pwdata/psel held stable; stay until pready of the selected slave is 1.
REQ-025 Completion edge: done=1 for the next cycle; slverr_out = pslverr of the selected slave; on read, apb_read_data_out = selected prdata slice.
REQ-026 apb_read_data_out SHALL hold its value until the next read completes; writes do not alter it.
REQ-027 At completion with transfer=1: latch the new request and go directly to SETUP (back-to-back, no IDLE cycle); otherwise go to IDLE with psel=0, penable=0.
REQ-028 transfer SHALL be ignored in SETUP and in non-completing ACCESS cycles.
REQ-029 Minimum latency: transfer sampled at edge k -> SETUP in cycle k+1, ACCESS in k+2, done in k+3 when pready=1 in ACCESS.
REQ-030 pready/pslverr/prdata of non-selected slaves SHALL be ignored.

Reset
REQ-031 presetn low SHALL immediately force state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, apb_read_data_out=0, busy=0, done=0, slverr_out=0.
REQ-032 Reset during SETUP/ACCESS SHALL abort the transfer with no done pulse; the first request after release is processed normally.

Configuration
REQ-033 With APB_TIMEOUT_EN defined: a counter SHALL run in ACCESS; after TIMEOUT cycles without pready, end the transfer with done=1, slverr_out=1, apb_read_data_out unchanged, and psel dropped.
REQ-034 Without APB_TIMEOUT_EN: no counter; ACCESS waits indefinitely; TIMEOUT has no effect.

Structure
REQ-035 Package apb_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS) and the default AW/DW/NS constants.
REQ-036 The address-to-one-hot decode SHALL be a sub-module apb_addr_decoder (parameters AW, NS).

Verification
REQ-037 Reset, write to 0xC5 (NS=4) data 0x3A, pready=1 -> psel=4'b1000, penable low in SETUP, done in the 3rd cycle, slverr_out=0.
REQ-038 Read from 0x12, slave 0 asserts pready after 3 wait cycles with prdata=0x5F -> penable high for 4 cycles, apb_read_data_out=0x5F, done once.
REQ-039 transfer held high for 3 writes -> SETUP follows each completion directly, no IDLE cycle, 3 done pulses.
REQ-040 Write to slave 2 with pslverr=1 at completion -> slverr_out=1; previous read data unchanged.
REQ-041 presetn pulsed low mid-ACCESS -> all outputs 0 immediately, no done; next request completes normally.
REQ-042 With APB_TIMEOUT_EN, TIMEOUT=16, pready held 0 -> done and slverr_out=1 after 16 ACCESS cycles, FSM back to IDLE.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and default sizes for the APB N-slave bridge.
// Holds the FSM state enum and the default AW/DW/NS constants.
package apb_pkg;

    localparam int APB_AW = 8;
    localparam int APB_DW = 8;
    localparam int APB_NS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

endpackage

// File: rtl/apb_nslave_bridge_if.sv
// apb_nslave_bridge_if: requester-side and APB-side signals of the bridge.
// Modports: master = bridge view (drives APB + status), slave = env view.
interface apb_nslave_bridge_if
    import apb_pkg::*;
#(
    parameter int AW = APB_AW,
    parameter int DW = APB_DW,
    parameter int NS = APB_NS
) ();

    logic             transfer;
    logic             READ_WRITE;
    logic [AW-1:0]    apb_write_paddr;
    logic [DW-1:0]    apb_write_data;
    logic [AW-1:0]    apb_read_paddr;
    logic [DW-1:0]    apb_read_data_out;
    logic             busy;
    logic             done;
    logic             slverr_out;

    logic [AW-1:0]    paddr;
    logic             pwrite;
    logic [DW-1:0]    pwdata;
    logic             penable;
    logic [NS-1:0]    psel;
    logic [NS*DW-1:0] prdata;
    logic [NS-1:0]    pready;
    logic [NS-1:0]    pslverr;

    modport master (
        input  transfer, READ_WRITE, apb_write_paddr,
        input  apb_write_data, apb_read_paddr,
        output apb_read_data_out, busy, done, slverr_out,
        output paddr, pwrite, pwdata, penable, psel,
        input  prdata, pready, pslverr
    );

    modport slave (
        output transfer, READ_WRITE, apb_write_paddr,
        output apb_write_data, apb_read_paddr,
        input  apb_read_data_out, busy, done, slverr_out,
        input  paddr, pwrite, pwdata, penable, psel,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: one-hot slave select from the top address bits.
// Ports: paddr (in, AW), psel (out, NS one-hot).
module apb_addr_decoder #(
    parameter int AW = 8,
    parameter int NS = 4
) (
    input  logic [AW-1:0] paddr,
    output logic [NS-1:0] psel
);

    localparam int SW = $clog2(NS);

    logic [SW-1:0] idx;

    assign idx = paddr[AW-1 -: SW];

    always_comb begin
        psel      = '0;
        psel[idx] = 1'b1;
    end

endmodule

// File: rtl/apb_nslave_bridge.sv
// apb_nslave_bridge: request -> APB master bridge for NS one-hot slaves.
// Ports: pclk, presetn (async, active low), bus (apb_nslave_bridge_if.master).
// Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
module apb_nslave_bridge
    import apb_pkg::*;
#(
    parameter int AW      = APB_AW,
    parameter int DW      = APB_DW,
    parameter int NS      = APB_NS,
    parameter int TIMEOUT = 16
) (
    input logic                 pclk,
    input logic                 presetn,
    apb_nslave_bridge_if.master bus
);

    state_t        state;
    logic [NS-1:0] psel_q;
    logic          penable_q;
    logic          pwrite_q;
    logic [AW-1:0] paddr_q;
    logic [DW-1:0] pwdata_q;
    logic [DW-1:0] rdata_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic [AW-1:0] req_addr;
    logic [NS-1:0] req_sel;
    logic          sel_ready;
    logic          sel_err;
    logic [DW-1:0] sel_rdata;
    logic          complete;
    logic          start;

    assign req_addr = bus.READ_WRITE ? bus.apb_read_paddr
                                     : bus.apb_write_paddr;

    apb_addr_decoder #(
        .AW (AW),
        .NS (NS)
    ) u_dec (
        .paddr (req_addr),
        .psel  (req_sel)
    );

    // The latched one-hot select masks out every other slave's response.
    assign sel_ready = |(bus.pready & psel_q);
    assign sel_err   = |(bus.pslverr & psel_q);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NS; i++) begin
            if (psel_q[i]) sel_rdata = bus.prdata[i*DW +: DW];
        end
    end

    assign complete = (state == ACCESS) && sel_ready;
    // A completing ACCESS may chain straight into the next SETUP.
    assign start    = bus.transfer && ((state == IDLE) || complete);

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          expire;
    assign expire = (state == ACCESS) && !sel_ready
                 && (cnt == CW'(TIMEOUT - 1));
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= IDLE;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: ;
                SETUP: begin
                    state     <= ACCESS;
                    penable_q <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    cnt       <= '0;
`endif
                end
                ACCESS: begin
                    if (sel_ready) begin
                        done_q    <= 1'b1;
                        err_q     <= sel_err;
                        if (!pwrite_q) rdata_q <= sel_rdata;
                        state     <= IDLE;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (expire) begin
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        state     <= IDLE;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
            // Later assignments win: a new request overrides the IDLE return.
            if (start) begin
                state     <= SETUP;
                psel_q    <= req_sel;
                penable_q <= 1'b0;
                busy_q    <= 1'b1;
                pwrite_q  <= !bus.READ_WRITE;
                paddr_q   <= req_addr;
                pwdata_q  <= bus.apb_write_data;
            end
        end
    end

    assign bus.psel              = psel_q;
    assign bus.penable           = penable_q;
    assign bus.pwrite            = pwrite_q;
    assign bus.paddr             = paddr_q;
    assign bus.pwdata            = pwdata_q;
    assign bus.apb_read_data_out = rdata_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.slverr_out        = err_q;

endmodule

// File: tb/tb_apb_nslave_bridge.sv
// tb_apb_nslave_bridge: randomized self-checking bench for apb_nslave_bridge.
// Reference model: per-transaction timeline derived from address/wait counts.
module tb_apb_nslave_bridge;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NS = 4;
    localparam int TO = 16;

    typedef struct {
        bit       rw;
        bit [7:0] addr;
        bit [7:0] wdata;
        int       waits;
        bit       err;
        bit [7:0] rdat;
    } txn_t;

    logic pclk;
    logic presetn;
    int   checks;
    int   errors;

    bit [7:0] exp_rd;
    bit       exp_err;
    txn_t     q[$];

    apb_nslave_bridge_if #(.AW(AW), .DW(DW), .NS(NS)) bus ();

    apb_nslave_bridge #(
        .AW(AW), .DW(DW), .NS(NS), .TIMEOUT(TO)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic bit [3:0] exp_sel(input bit [7:0] a);
        return 4'(1 << (a / (256 / NS)));
    endfunction

    function automatic txn_t rand_txn(input int max_wait);
        txn_t t;
        t.rw    = 1'($urandom);
        t.addr  = 8'($urandom);
        t.wdata = 8'($urandom);
        t.waits = int'($urandom_range(0, max_wait));
        t.err   = 1'($urandom);
        t.rdat  = 8'($urandom);
        return t;
    endfunction

    task automatic noise();
        bus.pready          = 4'($urandom);
        bus.pslverr         = 4'($urandom);
        bus.prdata          = 32'($urandom);
        bus.transfer        = 1'($urandom);
        bus.READ_WRITE      = 1'($urandom);
        bus.apb_write_paddr = 8'($urandom);
        bus.apb_read_paddr  = 8'($urandom);
        bus.apb_write_data  = 8'($urandom);
    endtask

    task automatic drive_req(input txn_t t);
        bus.transfer       = 1'b1;
        bus.READ_WRITE     = t.rw;
        bus.apb_write_data = t.wdata;
        if (t.rw) begin
            bus.apb_read_paddr  = t.addr;
            bus.apb_write_paddr = 8'($urandom);
        end else begin
            bus.apb_write_paddr = t.addr;
            bus.apb_read_paddr  = 8'($urandom);
        end
    endtask

    // Runs every queued transaction; called and returns on a negedge, idle.
    task automatic run_queue(input bit b2b);
        txn_t tr;
        bit   chained;
        int   s;
        chained = 1'b0;
        if (q.size() == 0) return;
        drive_req(q[0]);
        while (q.size() > 0) begin
            tr = q.pop_front();
            s  = tr.addr / (256 / NS);
            @(negedge pclk);
            checks++;
            if ({bus.busy, bus.penable, bus.psel, bus.paddr,
                 bus.pwrite, bus.pwdata, bus.done}
                !== {1'b1, 1'b0, exp_sel(tr.addr), tr.addr,
                     !tr.rw, tr.wdata, chained}) begin
                errors++;
                $display("FAIL setup: got %h want %h",
                    {bus.busy, bus.penable, bus.psel, bus.paddr,
                     bus.pwrite, bus.pwdata, bus.done},
                    {1'b1, 1'b0, exp_sel(tr.addr), tr.addr,
                     !tr.rw, tr.wdata, chained});
            end
            if (chained) begin
                checks++;
                if ({bus.slverr_out, bus.apb_read_data_out}
                    !== {exp_err, exp_rd}) begin
                    errors++;
                    $display("FAIL b2b_status: got %h want %h",
                        {bus.slverr_out, bus.apb_read_data_out},
                        {exp_err, exp_rd});
                end
            end
            noise();
            for (int j = 0; j <= tr.waits; j++) begin
                @(negedge pclk);
                checks++;
                if ({bus.busy, bus.penable, bus.psel, bus.paddr,
                     bus.pwrite, bus.pwdata, bus.done}
                    !== {1'b1, 1'b1, exp_sel(tr.addr), tr.addr,
                         !tr.rw, tr.wdata, 1'b0}) begin
                    errors++;
                    $display("FAIL access[%0d]: got %h want %h", j,
                        {bus.busy, bus.penable, bus.psel, bus.paddr,
                         bus.pwrite, bus.pwdata, bus.done},
                        {1'b1, 1'b1, exp_sel(tr.addr), tr.addr,
                         !tr.rw, tr.wdata, 1'b0});
                end
                noise();
                bus.pready[s] = (j == tr.waits);
                if (j == tr.waits) begin
                    bus.pslverr[s]          = tr.err;
                    bus.prdata[s*DW +: DW]  = tr.rdat;
                    if (b2b && q.size() > 0) drive_req(q[0]);
                    else bus.transfer = 1'b0;
                end
            end
            if (tr.rw) exp_rd = tr.rdat;
            exp_err = tr.err;
            chained = b2b && (q.size() > 0);
            if (!chained) begin
                @(negedge pclk);
                checks++;
                if ({bus.done, bus.busy, bus.psel, bus.penable,
                     bus.slverr_out, bus.apb_read_data_out}
                    !== {1'b1, 1'b0, 4'b0, 1'b0, exp_err, exp_rd}) begin
                    errors++;
                    $display("FAIL done: got %h want %h",
                        {bus.done, bus.busy, bus.psel, bus.penable,
                         bus.slverr_out, bus.apb_read_data_out},
                        {1'b1, 1'b0, 4'b0, 1'b0, exp_err, exp_rd});
                end
                if (q.size() > 0) drive_req(q[0]);
                else bus.transfer = 1'b0;
            end
        end
        @(negedge pclk);
        checks++;
        if ({bus.done, bus.busy, bus.psel} !== {1'b0, 1'b0, 4'b0}) begin
            errors++;
            $display("FAIL idle_after: got %h want %h",
                {bus.done, bus.busy, bus.psel}, 6'b0);
        end
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        noise();
        bus.transfer = 1'b0;
        exp_rd  = '0;
        exp_err = 1'b0;
        #2;
        checks++;
        if ({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata,
             bus.apb_read_data_out, bus.busy, bus.done, bus.slverr_out}
            !== '0) begin
            errors++;
            $display("FAIL reset_values: got %h want 0",
                {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata,
                 bus.apb_read_data_out, bus.busy, bus.done,
                 bus.slverr_out});
        end
        repeat (3) @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        checks++;
        if ({bus.busy, bus.done, bus.psel} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got %h want 0",
                {bus.busy, bus.done, bus.psel});
        end
    endtask

    task automatic test_write_basic();
        txn_t t;
        t = '{rw: 1'b0, addr: 8'hC5, wdata: 8'h3A, waits: 0,
              err: 1'b0, rdat: 8'h00};
        q.push_back(t);
        run_queue(1'b0);
    endtask

    task automatic test_read_wait();
        txn_t t;
        t = '{rw: 1'b1, addr: 8'h12, wdata: 8'h00, waits: 3,
              err: 1'b0, rdat: 8'h5F};
        q.push_back(t);
        run_queue(1'b0);
    endtask

    task automatic test_slverr();
        txn_t t;
        t = '{rw: 1'b0, addr: 8'h9C, wdata: 8'h77, waits: 1,
              err: 1'b1, rdat: 8'hEE};
        q.push_back(t);
        run_queue(1'b0);
    endtask

    task automatic test_back_to_back();
        txn_t t;
        for (int i = 0; i < 3; i++) begin
            t    = rand_txn(2);
            t.rw = 1'b0;
            q.push_back(t);
        end
        run_queue(1'b1);
        for (int i = 0; i < 15; i++) q.push_back(rand_txn(4));
        run_queue(1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) q.push_back(rand_txn(6));
        run_queue(1'b0);
    endtask

    task automatic test_reset_mid();
        txn_t t;
        t = '{rw: 1'b1, addr: 8'h4B, wdata: 8'h11, waits: 0,
              err: 1'b0, rdat: 8'hA5};
        q.push_back(t);
        run_queue(1'b0);
        t = '{rw: 1'b0, addr: 8'hE1, wdata: 8'h5C, waits: 0,
              err: 1'b0, rdat: 8'h00};
        drive_req(t);
        @(negedge pclk);
        noise();
        bus.transfer = 1'b0;
        bus.pready   = 4'b0;
        @(negedge pclk);
        bus.pready = 4'b0;
        #2 presetn = 1'b0;
        #1;
        checks++;
        if ({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata,
             bus.apb_read_data_out, bus.busy, bus.done, bus.slverr_out}
            !== '0) begin
            errors++;
            $display("FAIL reset_mid: got %h want 0",
                {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata,
                 bus.apb_read_data_out, bus.busy, bus.done,
                 bus.slverr_out});
        end
        exp_rd  = '0;
        exp_err = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_no_done: got %b want 00",
                {bus.done, bus.busy});
        end
        t = '{rw: 1'b1, addr: 8'h83, wdata: 8'h00, waits: 2,
              err: 1'b0, rdat: 8'h3C};
        q.push_back(t);
        run_queue(1'b0);
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        txn_t t;
        t = '{rw: 1'b1, addr: 8'h70, wdata: 8'h00, waits: 0,
              err: 1'b0, rdat: 8'h00};
        drive_req(t);
        @(negedge pclk);
        noise();
        bus.transfer = 1'b0;
        bus.pready   = 4'b0;
        for (int j = 0; j < TO; j++) begin
            @(negedge pclk);
            checks++;
            if ({bus.penable, bus.done} !== 2'b10) begin
                errors++;
                $display("FAIL timeout_wait[%0d]: got %b want 10", j,
                    {bus.penable, bus.done});
            end
            noise();
            bus.transfer = 1'b0;
            bus.pready   = 4'b0;
        end
        @(negedge pclk);
        checks++;
        if ({bus.done, bus.slverr_out, bus.psel, bus.penable, bus.busy,
             bus.apb_read_data_out}
            !== {1'b1, 1'b1, 4'b0, 1'b0, 1'b0, exp_rd}) begin
            errors++;
            $display("FAIL timeout_end: got %h want %h",
                {bus.done, bus.slverr_out, bus.psel, bus.penable,
                 bus.busy, bus.apb_read_data_out},
                {1'b1, 1'b1, 4'b0, 1'b0, 1'b0, exp_rd});
        end
        exp_err = 1'b1;
        @(negedge pclk);
        checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_idle: got %b want 00",
                {bus.done, bus.busy});
        end
    endtask
`else
    task automatic test_long_wait();
        txn_t t;
        t = '{rw: 1'b1, addr: 8'h66, wdata: 8'h00, waits: 24,
              err: 1'b0, rdat: 8'hC3};
        q.push_back(t);
        run_queue(1'b0);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_basic();
        test_read_wait();
        test_slverr();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
            checks, errors);
        $finish;
    end

endmodule
